// File: rtl/banked_regfile_if.sv
// Bus bundle for banked_regfile: read ports, EX/WB write ports, PC redirect and
// exception entry/return handshake. The core takes the slave view.
interface banked_regfile_if #(
    parameter int DATA_W    = 32,
    parameter int NUM_BANKS = 4
);
    localparam int BANK_W = $clog2(NUM_BANKS);

    logic              en;
    logic [3:0]        i_rm_code, i_rn_code, i_rs_code, i_re_code;
    logic [DATA_W-1:0] o_rm_reg, o_rn_reg, o_rs_reg, o_re_reg;
    logic [DATA_W-1:0] i_pc_next;
    logic              i_rd_en_ex, i_rd_en_wb;
    logic [3:0]        i_rd_code_ex, i_rd_code_wb;
    logic [DATA_W-1:0] i_rd_reg_ex, i_rd_reg_wb;
    logic              o_pc_en;
    logic [DATA_W-1:0] o_pc_reg;
    logic              i_exc_req;
    logic [BANK_W-1:0] i_exc_bank;
    logic [DATA_W-1:0] i_exc_lr;
    logic              i_ret_req;
    logic              o_exc_ack, o_exc_err, o_busy;
    logic [BANK_W-1:0] o_bank;

    modport slave (
        input  en, i_rm_code, i_rn_code, i_rs_code, i_re_code, i_pc_next,
               i_rd_en_ex, i_rd_code_ex, i_rd_reg_ex,
               i_rd_en_wb, i_rd_code_wb, i_rd_reg_wb,
               i_exc_req, i_exc_bank, i_exc_lr, i_ret_req,
        output o_rm_reg, o_rn_reg, o_rs_reg, o_re_reg, o_pc_en, o_pc_reg,
               o_exc_ack, o_exc_err, o_busy, o_bank
    );

    modport master (
        output en, i_rm_code, i_rn_code, i_rs_code, i_re_code, i_pc_next,
               i_rd_en_ex, i_rd_code_ex, i_rd_reg_ex,
               i_rd_en_wb, i_rd_code_wb, i_rd_reg_wb,
               i_exc_req, i_exc_bank, i_exc_lr, i_ret_req,
        input  o_rm_reg, o_rn_reg, o_rs_reg, o_re_reg, o_pc_en, o_pc_reg,
               o_exc_ack, o_exc_err, o_busy, o_bank
    );
endinterface

// File: rtl/banked_regfile.sv
// Register file with shared low registers and per-bank high registers (r14 is the
// link register), plus a small FSM for exception entry and return between banks.
module banked_regfile #(
    parameter int DATA_W    = 32,
    parameter int NUM_BANKS = 4,
    parameter int BANK_LO   = 13
) (
    input  logic             clk,
    input  logic             rst,
    banked_regfile_if.slave  bus
);
    localparam int BANK_W = $clog2(NUM_BANKS);
    localparam int NB     = 15 - BANK_LO;

    typedef enum logic [1:0] {IDLE, ENTER, RETURN} state_t;

    state_t            state_reg, state_next;
    logic [BANK_W-1:0] bank_reg, bank_next;
    logic [DATA_W-1:0] ret_pc_reg, ret_pc_next;
    logic              err_reg, err_next;

    logic [DATA_W-1:0] view [16];
    logic [DATA_W-1:0] banked_q [NUM_BANKS][NB];
    logic [BANK_W-1:0] prev_q [NUM_BANKS];

    logic idle, commit, ex_hit15, wb_hit15, wr_ex, wr_wb;
    logic exc_valid, exc_accept, ret_accept, req_error;

    assign idle       = (state_reg == IDLE);
    assign commit     = bus.en && idle;
    assign ex_hit15   = bus.i_rd_en_ex && (bus.i_rd_code_ex == 4'd15);
    assign wb_hit15   = bus.i_rd_en_wb && (bus.i_rd_code_wb == 4'd15);
    assign wr_ex      = commit && bus.i_rd_en_ex && !ex_hit15;
    assign wr_wb      = commit && bus.i_rd_en_wb && !wb_hit15;
    assign exc_valid  = (bus.i_exc_bank != bank_reg) && (int'(bus.i_exc_bank) < NUM_BANKS);
    assign exc_accept = commit && bus.i_exc_req && exc_valid;
    assign ret_accept = commit && bus.i_ret_req && !bus.i_exc_req && (bank_reg != '0);
    assign req_error  = commit && ((bus.i_exc_req && !exc_valid) ||
                                   (bus.i_ret_req && !bus.i_exc_req && (bank_reg == '0)));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg  <= IDLE;
            bank_reg   <= '0;
            ret_pc_reg <= '0;
            err_reg    <= 1'b0;
        end else begin
            state_reg  <= state_next;
            bank_reg   <= bank_next;
            ret_pc_reg <= ret_pc_next;
            err_reg    <= err_next;
        end
    end

    always_comb begin
        state_next  = state_reg;
        bank_next   = bank_reg;
        ret_pc_next = ret_pc_reg;
        err_next    = err_reg;
        if (bus.en) begin
            err_next = req_error;
            case (state_reg)
                IDLE: begin
                    if (exc_accept) begin
                        state_next = ENTER;
                        bank_next  = bus.i_exc_bank;
                    end else if (ret_accept) begin
                        state_next  = RETURN;
                        bank_next   = prev_q[bank_reg];
                        ret_pc_next = view[14];
                    end
                end
                default: state_next = IDLE;
            endcase
        end
    end

    genvar gi, gj;

    // Shared registers: visible from every bank.
    for (gi = 0; gi < BANK_LO; gi++) begin : g_shared
        logic [DATA_W-1:0] q_reg;
        logic              sel_ex, sel_wb;
        assign sel_ex = wr_ex && (bus.i_rd_code_ex == 4'(gi));
        assign sel_wb = wr_wb && (bus.i_rd_code_wb == 4'(gi));
        always_ff @(posedge clk) begin
            if (rst)         q_reg <= '0;
            else if (sel_ex) q_reg <= bus.i_rd_reg_ex;
            else if (sel_wb) q_reg <= bus.i_rd_reg_wb;
        end
        assign view[gi] = q_reg;
    end

    for (gi = 0; gi < NUM_BANKS; gi++) begin : g_bank
        logic [BANK_W-1:0] prev_reg;
        logic              mine, entry;
        assign mine  = (bank_reg == BANK_W'(gi));
        assign entry = exc_accept && (bus.i_exc_bank == BANK_W'(gi));
        always_ff @(posedge clk) begin
            if (rst)        prev_reg <= '0;
            else if (entry) prev_reg <= bank_reg;
        end
        assign prev_q[gi] = prev_reg;

        for (gj = 0; gj < NB; gj++) begin : g_reg
            logic [DATA_W-1:0] q_reg;
            logic              sel_ex, sel_wb, lr_load;
            assign sel_ex  = wr_ex && mine && (bus.i_rd_code_ex == 4'(BANK_LO + gj));
            assign sel_wb  = wr_wb && mine && (bus.i_rd_code_wb == 4'(BANK_LO + gj));
            // Only the link register of the target bank captures the return address.
            assign lr_load = entry && (BANK_LO + gj == 14);
            always_ff @(posedge clk) begin
                if (rst)          q_reg <= '0;
                else if (lr_load) q_reg <= bus.i_exc_lr;
                else if (sel_ex)  q_reg <= bus.i_rd_reg_ex;
                else if (sel_wb)  q_reg <= bus.i_rd_reg_wb;
            end
            assign banked_q[gi][gj] = q_reg;
        end
    end

    for (gi = BANK_LO; gi < 15; gi++) begin : g_view
        assign view[gi] = banked_q[bank_reg][gi-BANK_LO];
    end
    assign view[15] = bus.i_pc_next;

    logic [3:0]        rd_code [4];
    logic [DATA_W-1:0] rd_data [4];
    assign rd_code[0] = bus.i_rm_code;
    assign rd_code[1] = bus.i_rn_code;
    assign rd_code[2] = bus.i_rs_code;
    assign rd_code[3] = bus.i_re_code;

    for (gi = 0; gi < 4; gi++) begin : g_read
        logic [DATA_W-1:0] data;
        always_comb begin
            data = view[rd_code[gi]];
            if (idle && rd_code[gi] != 4'd15) begin
                if (bus.i_rd_en_ex && bus.i_rd_code_ex == rd_code[gi])      data = bus.i_rd_reg_ex;
                else if (bus.i_rd_en_wb && bus.i_rd_code_wb == rd_code[gi]) data = bus.i_rd_reg_wb;
            end
        end
        assign rd_data[gi] = data;
    end

    assign bus.o_rm_reg  = rd_data[0];
    assign bus.o_rn_reg  = rd_data[1];
    assign bus.o_rs_reg  = rd_data[2];
    assign bus.o_re_reg  = rd_data[3];
    assign bus.o_busy    = !idle;
    assign bus.o_exc_ack = (state_reg == ENTER);
    assign bus.o_exc_err = err_reg;
    assign bus.o_bank    = bank_reg;

    always_comb begin
        bus.o_pc_en  = 1'b0;
        bus.o_pc_reg = wb_hit15 ? bus.i_rd_reg_wb : bus.i_rd_reg_ex;
        case (state_reg)
            IDLE:    bus.o_pc_en = ex_hit15 || wb_hit15;
            RETURN: begin
                bus.o_pc_en  = 1'b1;
                bus.o_pc_reg = ret_pc_reg;
            end
            default: bus.o_pc_en = 1'b0;
        endcase
    end
endmodule

// File: tb/tb_banked_regfile.sv
// Directed bench for banked_regfile: a register-array model predicts every output
// each cycle, and literal expectations pin the key scenarios.
`timescale 1ns/1ps
module tb_banked_regfile;
    localparam int DW = 32;
    localparam int NBK = 4;
    localparam int LO = 13;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    banked_regfile_if #(.DATA_W(DW), .NUM_BANKS(NBK)) bus ();
    banked_regfile #(.DATA_W(DW), .NUM_BANKS(NBK), .BANK_LO(LO)) dut (
        .clk(clk), .rst(rst), .bus(bus.slave)
    );

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    bit checking = 1'b0;

    // Model: shared registers, one full 15-entry set per bank, and a phase
    // (0 = no operation, 1 = entering, 2 = returning).
    logic [DW-1:0] shared_m [15];
    logic [DW-1:0] bregs_m [NBK][15];
    logic [1:0]    prev_m [NBK];
    logic [DW-1:0] ret_pc_m;
    logic [1:0]    bank_m;
    int            phase_m;
    logic          err_m;

    task automatic cmp(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s cycle=%0d actual=%h required=%h", name, cyc, act, exp);
        end
    endtask

    function automatic logic [DW-1:0] stored(input logic [3:0] c);
        if (int'(c) < LO) return shared_m[c];
        return bregs_m[bank_m][c];
    endfunction

    function automatic logic [DW-1:0] exp_read(input logic [3:0] c);
        if (c == 4'd15) return bus.i_pc_next;
        if (phase_m == 0 && bus.i_rd_en_ex && bus.i_rd_code_ex == c) return bus.i_rd_reg_ex;
        if (phase_m == 0 && bus.i_rd_en_wb && bus.i_rd_code_wb == c) return bus.i_rd_reg_wb;
        return stored(c);
    endfunction

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rst) begin
            for (int k = 0; k < 15; k++) shared_m[k] <= '0;
            for (int b = 0; b < NBK; b++) begin
                prev_m[b] <= '0;
                for (int k = 0; k < 15; k++) bregs_m[b][k] <= '0;
            end
            ret_pc_m <= '0;
            bank_m   <= '0;
            phase_m  <= 0;
            err_m    <= 1'b0;
        end else if (bus.en) begin
            err_m <= 1'b0;
            if (phase_m != 0) begin
                phase_m <= 0;
            end else begin
                if (bus.i_rd_en_wb && bus.i_rd_code_wb != 4'd15) begin
                    if (int'(bus.i_rd_code_wb) < LO) shared_m[bus.i_rd_code_wb] <= bus.i_rd_reg_wb;
                    else bregs_m[bank_m][bus.i_rd_code_wb] <= bus.i_rd_reg_wb;
                end
                if (bus.i_rd_en_ex && bus.i_rd_code_ex != 4'd15) begin
                    if (int'(bus.i_rd_code_ex) < LO) shared_m[bus.i_rd_code_ex] <= bus.i_rd_reg_ex;
                    else bregs_m[bank_m][bus.i_rd_code_ex] <= bus.i_rd_reg_ex;
                end
                if (bus.i_exc_req) begin
                    if (bus.i_exc_bank != bank_m && int'(bus.i_exc_bank) < NBK) begin
                        bregs_m[bus.i_exc_bank][14] <= bus.i_exc_lr;
                        prev_m[bus.i_exc_bank] <= bank_m;
                        bank_m  <= bus.i_exc_bank;
                        phase_m <= 1;
                    end else err_m <= 1'b1;
                end else if (bus.i_ret_req) begin
                    if (bank_m != 0) begin
                        ret_pc_m <= bregs_m[bank_m][14];
                        bank_m   <= prev_m[bank_m];
                        phase_m  <= 2;
                    end else err_m <= 1'b1;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (checking) begin
            logic wb15, ex15;
            wb15 = bus.i_rd_en_wb && bus.i_rd_code_wb == 4'd15;
            ex15 = bus.i_rd_en_ex && bus.i_rd_code_ex == 4'd15;
            cmp("m_rm", bus.o_rm_reg, exp_read(bus.i_rm_code));
            cmp("m_rn", bus.o_rn_reg, exp_read(bus.i_rn_code));
            cmp("m_rs", bus.o_rs_reg, exp_read(bus.i_rs_code));
            cmp("m_re", bus.o_re_reg, exp_read(bus.i_re_code));
            cmp("m_busy", DW'(bus.o_busy), DW'(phase_m != 0));
            cmp("m_ack", DW'(bus.o_exc_ack), DW'(phase_m == 1));
            cmp("m_err", DW'(bus.o_exc_err), DW'(err_m));
            cmp("m_bank", DW'(bus.o_bank), DW'(bank_m));
            cmp("m_pc_en", DW'(bus.o_pc_en),
                DW'(phase_m == 2 || (phase_m == 0 && (ex15 || wb15))));
            cmp("m_pc_reg", bus.o_pc_reg,
                phase_m == 2 ? ret_pc_m : (wb15 ? bus.i_rd_reg_wb : bus.i_rd_reg_ex));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_in();
        bus.i_rd_en_ex = 0; bus.i_rd_code_ex = 0; bus.i_rd_reg_ex = 0;
        bus.i_rd_en_wb = 0; bus.i_rd_code_wb = 0; bus.i_rd_reg_wb = 0;
        bus.i_exc_req = 0; bus.i_exc_bank = 0; bus.i_exc_lr = 0; bus.i_ret_req = 0;
    endtask

    task automatic ex_wr(input logic [3:0] c, input logic [DW-1:0] v);
        bus.i_rd_en_ex = 1; bus.i_rd_code_ex = c; bus.i_rd_reg_ex = v;
    endtask

    task automatic wb_wr(input logic [3:0] c, input logic [DW-1:0] v);
        bus.i_rd_en_wb = 1; bus.i_rd_code_wb = c; bus.i_rd_reg_wb = v;
    endtask

    task automatic exc(input logic [1:0] b, input logic [DW-1:0] lr);
        bus.i_exc_req = 1; bus.i_exc_bank = b; bus.i_exc_lr = lr;
    endtask

    initial begin
        rst = 1; bus.en = 1; bus.i_pc_next = 0;
        bus.i_rm_code = 0; bus.i_rn_code = 0; bus.i_rs_code = 0; bus.i_re_code = 0;
        idle_in();
        tick(); checking = 1'b1;
        tick(); rst = 0;
        @(negedge clk);
        cmp("rst_busy", DW'(bus.o_busy), 0);
        cmp("rst_ack", DW'(bus.o_exc_ack), 0);
        cmp("rst_err", DW'(bus.o_exc_err), 0);
        cmp("rst_pc_en", DW'(bus.o_pc_en), 0);
        cmp("rst_pc_reg", bus.o_pc_reg, 0);
        cmp("rst_bank", DW'(bus.o_bank), 0);
        cmp("rst_r0", bus.o_rm_reg, 0);
        tick();

        ex_wr(0, 32'h11);
        @(negedge clk); cmp("byp_r0", bus.o_rm_reg, 32'h11);
        tick(); idle_in();

        // EX and WB collide on r3: EX wins, both for bypass and storage.
        ex_wr(3, 32'hAAAA0000); wb_wr(3, 32'h5555); bus.i_rm_code = 3;
        @(negedge clk); cmp("ex_wins_byp", bus.o_rm_reg, 32'hAAAA0000);
        tick(); idle_in();
        @(negedge clk); cmp("ex_wins_store", bus.o_rm_reg, 32'hAAAA0000);
        tick();

        wb_wr(5, 32'h77); ex_wr(15, 32'h40); bus.i_rn_code = 5;
        @(negedge clk);
        cmp("wb_byp", bus.o_rn_reg, 32'h77);
        cmp("pc_ex_en", DW'(bus.o_pc_en), 1);
        cmp("pc_ex_val", bus.o_pc_reg, 32'h40);
        tick(); idle_in();

        ex_wr(15, 32'h40); wb_wr(15, 32'h80); bus.i_pc_next = 32'h1234;
        bus.i_re_code = 15; bus.i_rs_code = 5;
        @(negedge clk);
        cmp("pc_wb_val", bus.o_pc_reg, 32'h80);
        cmp("r15_read", bus.o_re_reg, 32'h1234);
        cmp("r5_stored", bus.o_rs_reg, 32'h77);
        tick(); idle_in();

        bus.en = 0; ex_wr(2, 32'h5); bus.i_rm_code = 2;
        tick(); idle_in(); bus.en = 1;
        @(negedge clk); cmp("en0_no_write", bus.o_rm_reg, 0);
        tick();

        // Bank 0 r13, then enter bank 2.
        ex_wr(13, 32'h100);
        tick(); idle_in();
        exc(2, 32'h2000);
        @(negedge clk); cmp("ack_not_yet", DW'(bus.o_exc_ack), 0);
        tick(); idle_in();
        wb_wr(1, 32'h99);
        bus.i_rm_code = 13; bus.i_rn_code = 14; bus.i_rs_code = 0; bus.i_re_code = 1;
        @(negedge clk);
        cmp("enter_ack", DW'(bus.o_exc_ack), 1);
        cmp("enter_busy", DW'(bus.o_busy), 1);
        cmp("enter_bank", DW'(bus.o_bank), 2);
        cmp("enter_pc_en", DW'(bus.o_pc_en), 0);
        cmp("b2_r13", bus.o_rm_reg, 0);
        cmp("b2_r14", bus.o_rn_reg, 32'h2000);
        cmp("b2_r0", bus.o_rs_reg, 32'h11);
        tick(); idle_in();
        @(negedge clk);
        cmp("enter_wb_dropped", bus.o_re_reg, 0);
        cmp("ack_gone", DW'(bus.o_exc_ack), 0);
        tick();

        exc(2, 32'h0);
        @(negedge clk); cmp("err_not_yet", DW'(bus.o_exc_err), 0);
        tick(); idle_in();
        @(negedge clk);
        cmp("err_same_bank", DW'(bus.o_exc_err), 1);
        cmp("err_bank_kept", DW'(bus.o_bank), 2);
        tick();
        @(negedge clk); cmp("err_one_pulse", DW'(bus.o_exc_err), 0);

        bus.i_ret_req = 1;
        tick(); idle_in();
        @(negedge clk);
        cmp("ret_pc_en", DW'(bus.o_pc_en), 1);
        cmp("ret_pc", bus.o_pc_reg, 32'h2000);
        cmp("ret_bank", DW'(bus.o_bank), 0);
        tick();
        @(negedge clk);
        cmp("b0_r13", bus.o_rm_reg, 32'h100);
        cmp("ret_done_pc_en", DW'(bus.o_pc_en), 0);

        bus.i_ret_req = 1;
        tick(); idle_in();
        @(negedge clk); cmp("err_ret_b0", DW'(bus.o_exc_err), 1);
        tick();

        exc(1, 32'h300);
        tick(); idle_in();
        tick();
        exc(3, 32'h3000); bus.i_ret_req = 1;
        tick(); idle_in();
        wb_wr(2, 32'hDEAD); bus.i_rm_code = 2;
        @(negedge clk);
        cmp("prio_bank", DW'(bus.o_bank), 3);
        cmp("prio_ack", DW'(bus.o_exc_ack), 1);
        tick(); idle_in();
        @(negedge clk);
        cmp("prio_no_err", DW'(bus.o_exc_err), 0);
        cmp("enter_wb_r2", bus.o_rm_reg, 0);
        bus.i_ret_req = 1;
        tick(); idle_in();
        @(negedge clk);
        cmp("prev3_bank", DW'(bus.o_bank), 1);
        cmp("ret3_pc", bus.o_pc_reg, 32'h3000);
        tick();

        bus.i_ret_req = 1;
        tick(); idle_in();
        rst = 1;
        @(negedge clk); cmp("ret1_pc", bus.o_pc_reg, 32'h300);
        tick(); rst = 0;
        @(negedge clk);
        cmp("abort_pc_en", DW'(bus.o_pc_en), 0);
        cmp("abort_busy", DW'(bus.o_busy), 0);
        cmp("abort_bank", DW'(bus.o_bank), 0);
        for (int k = 0; k < 15; k++) begin
            tick();
            bus.i_rm_code = 4'(k);
            @(negedge clk); cmp("abort_zero", bus.o_rm_reg, 0);
        end
        tick();
        checking = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/banked_regfile.md
BANKED_REGFILE -- requirements
Module: banked_regfile

Interface
REQ-001 Parameter DATA_W, default 32, register width in bits.
REQ-002 Parameter NUM_BANKS, default 4, legal 2..8, number of register banks; bank 0 is the user bank; BANK_W = clog2(NUM_BANKS).
REQ-003 Parameter BANK_LO, default 13, legal 8..14, lowest banked register index; r0..r(BANK_LO-1) are shared and r(BANK_LO)..r14 are per-bank.
REQ-004 clk  input  1  sole clock; all state updates on its rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 en  input  1  global enable; en=0 freezes all registered state, including the FSM.
REQ-007 i_rm_code, i_rn_code, i_rs_code, i_re_code  input  4 each  read port addresses.
REQ-008 o_rm_reg, o_rn_reg, o_rs_reg, o_re_reg  output  DATA_W each  combinational read data.
REQ-009 i_pc_next  input  DATA_W  value returned for any read of r15.
REQ-010 i_rd_en_ex, i_rd_code_ex, i_rd_reg_ex  input  1/4/DATA_W  EX-stage write port.
REQ-011 i_rd_en_wb, i_rd_code_wb, i_rd_reg_wb  input  1/4/DATA_W  WB-stage write port.
REQ-012 o_pc_en, o_pc_reg  output  1/DATA_W  PC redirect strobe and target.
REQ-013 i_exc_req, i_exc_bank, i_exc_lr  input  1/BANK_W/DATA_W  exception entry request, target bank, and return address.
REQ-014 i_ret_req  input  1  exception return request.
REQ-015 o_exc_ack, o_exc_err  output  1 each  one-cycle accept and reject pulses.
REQ-016 o_busy  output  1  high while the FSM is not in IDLE; the pipeline shall stall on it.
REQ-017 o_bank  output  BANK_W  current bank, registered.

Function
REQ-018 The FSM shall have exactly three states, IDLE, ENTER and RETURN; ENTER and RETURN shall each last one enabled cycle and then return to IDLE.
REQ-019 Read: code 15 shall return i_pc_next; otherwise a matching enabled EX write in IDLE; else a matching enabled WB write in IDLE; else the stored value (shared, or banked for o_bank).
REQ-020 Writes shall commit only when en=1 and state=IDLE, to the bank given by o_bank before any switch at that edge; when EX and WB target the same register, EX wins.
REQ-021 Writes to r15 shall not be stored; in IDLE, o_pc_en = (EX write to 15) | (WB write to 15), and o_pc_reg = WB value if the WB write targets 15, else the EX value.
REQ-022 Exception accept: IDLE & en & i_exc_req & i_exc_bank != o_bank & i_exc_bank < NUM_BANKS -> at that edge r14[i_exc_bank] <= i_exc_lr, prev[i_exc_bank] <= o_bank, o_bank <= i_exc_bank, state <= ENTER.
REQ-023 In ENTER: o_busy=1, o_exc_ack=1, o_pc_en=0; EX/WB writes are dropped.
REQ-024 Return accept: IDLE & en & i_ret_req & !i_exc_req & o_bank != 0 -> ret_pc <= r14[o_bank], o_bank <= prev[o_bank], state <= RETURN.
REQ-025 In RETURN: o_busy=1, o_pc_en=1, o_pc_reg=ret_pc; EX/WB writes are dropped.
REQ-026 When i_exc_req and i_ret_req are both high, the exception shall take priority and the return shall be ignored, with no error.
REQ-027 An invalid exception (target equals o_bank, or target >= NUM_BANKS), or a return while o_bank=0, shall pulse o_exc_err in the next cycle, with state, bank and registers unchanged except that the IDLE-cycle writes still commit.
REQ-028 Requests presented while o_busy=1 shall be ignored, with no error.

Reset
REQ-029 When rst=1 at an edge, all shared, banked, prev and ret_pc registers shall be set to 0, o_bank=0 and state=IDLE; rst overrides en.
REQ-030 After reset, o_busy, o_exc_ack, o_exc_err and o_pc_en shall be 0, and o_pc_reg shall equal the EX value (0 when idle inputs are 0).
REQ-031 A reset asserted during ENTER or RETURN shall abort the operation: no ack and no PC pulse follow.

Verification
REQ-032 EX writes r3=0xAAAA0000 and WB writes r3=0x5555 in the same cycle -> r3 reads 0xAAAA0000 next cycle; a same-cycle read of r3 bypasses 0xAAAA0000.
REQ-033 In bank 0, write r13=0x100; exc_req bank 2 with lr=0x2000 -> ack 1 cycle later, o_bank=2, r14 reads 0x2000, r13 reads 0, and r0 is unchanged.
REQ-034 From bank 2, exc_req bank 2 -> o_exc_err pulse, o_bank stays 2; from bank 0, ret_req -> o_exc_err.
REQ-035 In bank 2 (entered from 0 with lr=0x2000), ret_req -> next cycle o_pc_en=1, o_pc_reg=0x2000, o_bank=0, and bank-0 r13 reads 0x100.
REQ-036 exc_req and ret_req together in bank 1 targeting bank 3 -> entry to bank 3, prev[3]=1; a WB write presented during ENTER is dropped.
REQ-037 rst pulsed during RETURN -> no further o_pc_en, o_bank=0, all reads of r0..r14 return 0.
